// File: rtl/counter_updown_mod.sv
// ---------------------------------------------------------------------------
// counter_updown_mod
//
// Modulo-MODULO up/down counter with synchronous clear and load, a registered
// wrap pulse, a registered out-of-range-load pulse and a saturating wrap
// event counter. Control priority on each rising edge: clr > load > en > hold.
//
// Parameters
//   WIDTH    count register width in bits
//   MODULO   count range 0..MODULO-1 (2 <= MODULO <= 2**WIDTH)
//   WRAP_W   width of the saturating wrap event counter
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   clr       in   synchronous clear of count, wrap, load_err and wrap_cnt
//   load      in   synchronous load of load_val
//   load_val  in   value to load (WIDTH bits)
//   en        in   count enable
//   up_dn     in   direction: 1 = up, 0 = down
//   count     out  current count, registered
//   tc        out  terminal count for the current direction, combinational
//   wrap      out  one-cycle pulse on the edge that registers a wrapped count
//   load_err  out  one-cycle pulse on a load with load_val >= MODULO
//   wrap_cnt  out  saturating number of wraps since reset or clr
// ---------------------------------------------------------------------------
module counter_updown_mod #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              en,
    input  logic              up_dn,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              wrap,
    output logic              load_err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    // Largest legal count; fits in WIDTH bits because MODULO <= 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    // MODULO itself may equal 2**WIDTH, so it needs one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0]  count_nxt;
    logic              wrap_nxt;
    logic              load_err_nxt;
    logic [WRAP_W-1:0] wrap_cnt_nxt;
    logic              load_oor;

    // Out-of-range load check done at WIDTH+1 bits so MODULO == 2**WIDTH
    // (where every load is legal) needs no special case.
    assign load_oor = ({1'b0, load_val} >= MOD_EXT);

    // Terminal count depends on the live direction, not a registered copy.
    assign tc = up_dn ? (count == MAX_VAL) : (count == '0);

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path leaves a signal unassigned and no latch is inferred.
        count_nxt    = count;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        wrap_cnt_nxt = wrap_cnt;

        if (clr) begin
            count_nxt    = '0;
            wrap_cnt_nxt = '0;
        end else if (load) begin
            if (load_oor) begin
                count_nxt    = MAX_VAL;
                load_err_nxt = 1'b1;
            end else begin
                count_nxt = load_val;
            end
        end else if (en) begin
            if (up_dn) begin
                if (count == MAX_VAL) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_nxt = MAX_VAL;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end

        // Saturate rather than roll over once all ones is reached.
        if (wrap_nxt && (wrap_cnt != '1)) begin
            wrap_cnt_nxt = wrap_cnt + 1'b1;
        end
    end

    // NOTE: the reset branch is asynchronous so outputs clear the moment rst
    // falls, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            wrap_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
            wrap_cnt <= wrap_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_mod
//
// Self-checking bench for counter_updown_mod at WIDTH=4, MODULO=10, WRAP_W=2.
// A reference model written with plain integer arithmetic (modulo, clamping,
// saturation) predicts every registered output; directed scenarios are
// followed by randomized control traffic.
// ---------------------------------------------------------------------------
module tb_counter_updown_mod;

    localparam int WIDTH  = 4;
    localparam int MODULO = 10;
    localparam int WRAP_W = 2;
    localparam int WC_MAX = (1 << WRAP_W) - 1;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic              en;
    logic              up_dn;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              wrap;
    logic              load_err;
    logic [WRAP_W-1:0] wrap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_count;
    int m_wrap;
    int m_load_err;
    int m_wrap_cnt;

    counter_updown_mod #(
        .WIDTH (WIDTH),
        .MODULO(MODULO),
        .WRAP_W(WRAP_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .load    (load),
        .load_val(load_val),
        .en      (en),
        .up_dn   (up_dn),
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .load_err(load_err),
        .wrap_cnt(wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int model_tc(input int cnt, input logic dir);
        if (dir) return (cnt == MODULO - 1) ? 1 : 0;
        return (cnt == 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_count    = 0;
        m_wrap     = 0;
        m_load_err = 0;
        m_wrap_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"},    int'(count),    m_count);
        check({tag, ".wrap"},     int'(wrap),     m_wrap);
        check({tag, ".load_err"}, int'(load_err), m_load_err);
        check({tag, ".wrap_cnt"}, int'(wrap_cnt), m_wrap_cnt);
        check({tag, ".tc"},       int'(tc),       model_tc(m_count, up_dn));
    endtask

    // Drive one set of controls, advance one edge, update the model and
    // compare everything 1 time unit after the edge.
    task automatic step(input string tag, input logic c, input logic l,
                        input logic [WIDTH-1:0] lv, input logic e, input logic u);
        int nxt;
        clr      = c;
        load     = l;
        load_val = lv;
        en       = e;
        up_dn    = u;
        @(posedge clk);
        m_wrap     = 0;
        m_load_err = 0;
        if (c) begin
            m_count    = 0;
            m_wrap_cnt = 0;
        end else if (l) begin
            if (int'(lv) < MODULO) m_count = int'(lv);
            else begin
                m_count    = MODULO - 1;
                m_load_err = 1;
            end
        end else if (e) begin
            nxt = u ? m_count + 1 : m_count - 1;
            if (nxt >= MODULO || nxt < 0) begin
                m_wrap = 1;
                if (m_wrap_cnt < WC_MAX) m_wrap_cnt = m_wrap_cnt + 1;
            end
            m_count = (nxt + MODULO) % MODULO;
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        rst      = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        up_dn    = 1'b0;
        model_reset();

        // Reset state, including tc for both directions while in reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst.count",    int'(count),    0);
        check("rst.wrap",     int'(wrap),     0);
        check("rst.load_err", int'(load_err), 0);
        check("rst.wrap_cnt", int'(wrap_cnt), 0);
        check("rst.tc_down",  int'(tc),       1);
        up_dn = 1'b1;
        #1;
        check("rst.tc_up",    int'(tc),       0);
        @(negedge clk);
        rst = 1'b1;

        // Twelve up-counts from zero: 1..9, 0, 1, 2 with a single wrap.
        for (int i = 0; i < 12; i++) step("up12", 0, 0, '0, 1, 1);
        check("up12.final_count", int'(count), 2);
        check("up12.final_wraps", int'(wrap_cnt), 1);

        // Down-count from zero wraps to MODULO-1; tc follows up_dn live.
        step("clr0", 1, 0, '0, 0, 0);
        step("down_wrap", 0, 0, '0, 1, 0);
        check("down_wrap.count", int'(count), 9);
        check("down_wrap.wrap",  int'(wrap), 1);
        check("down_wrap.tc",    int'(tc), 0);
        up_dn = 1'b1;
        #1;
        check("down_wrap.tc_up", int'(tc), 1);
        step("hold_after_down", 0, 0, '0, 0, 1);

        // Out-of-range load clamps and pulses load_err; legal load does not.
        step("load12", 0, 1, 4'd12, 0, 1);
        check("load12.count",    int'(count), 9);
        check("load12.load_err", int'(load_err), 1);
        step("load5", 0, 1, 4'd5, 0, 1);
        check("load5.count",    int'(count), 5);
        check("load5.load_err", int'(load_err), 0);
        step("load15", 0, 1, 4'd15, 0, 0);
        step("load_err_clears", 0, 0, '0, 0, 0);

        // Priority: clr beats load and en; load beats en.
        step("clr_load_en", 1, 1, 4'd6, 1, 1);
        check("clr_load_en.count", int'(count), 0);
        check("clr_load_en.wraps", int'(wrap_cnt), 0);
        step("load_en", 0, 1, 4'd8, 1, 1);
        check("load_en.count", int'(count), 8);

        // Five up-wraps saturate wrap_cnt at 3; then hold with en=0.
        step("clr1", 1, 0, '0, 0, 1);
        for (int i = 0; i < 5 * MODULO; i++) step("sat", 0, 0, '0, 1, 1);
        check("sat.wrap_cnt", int'(wrap_cnt), 3);
        step("sat_hold", 0, 0, '0, 0, 1);
        check("sat_hold.wrap", int'(wrap), 0);
        check("sat_hold.wrap_cnt", int'(wrap_cnt), 3);

        // Asynchronous reset between edges at count=7.
        step("load7", 0, 1, 4'd7, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_rst.count",    int'(count), 0);
        check("async_rst.wrap_cnt", int'(wrap_cnt), 0);
        compare_all("async_rst");
        #1;
        rst = 1'b1;
        step("after_rst", 0, 0, '0, 1, 1);

        // Randomized control traffic.
        for (int i = 0; i < 400; i++) begin
            logic c, l, e, u;
            logic [WIDTH-1:0] lv;
            c  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 7) == 0);
            e  = ($urandom_range(0, 3) != 0);
            u  = ($urandom_range(0, 2) != 0);
            lv = WIDTH'($urandom_range(0, 15));
            step("rand", c, l, lv, e, u);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
